// File: rtl/conv_mem_pkg.sv
// Shared types and constants for the convolution weight-memory address generator.
// Defaults reproduce the conv2 layer geometry.
package conv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CONV2_TAPS        = 25;
    localparam int CONV2_PASSES      = 64;
    localparam int CONV2_GROUPS      = 3;
    localparam int CONV2_PORT_STRIDE = 75;

    // Highest address any port can reach must fit in the address width.
    function automatic bit addr_range_ok(
        input int base,
        input int taps,
        input int groups,
        input int ports,
        input int stride,
        input int aw
    );
        longint top;
        top = longint'(base) + longint'(groups) * taps - 1
            + longint'(ports - 1) * stride;
        return top < (longint'(1) << aw);
    endfunction

endpackage

// File: rtl/lat_pipe.sv
// Async-reset shift register that aligns control markers with memory read data.
// DEPTH=0 is a plain wire.
module lat_pipe #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_regs
        logic [W-1:0] r [DEPTH];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) r[i] <= '0;
            end else begin
                r[0] <= d;
                for (int i = 1; i < DEPTH; i++) r[i] <= r[i-1];
            end
        end

        assign q = r[DEPTH-1];
    end

endmodule

// File: rtl/conv_k_mem_addr_gen.sv
// Kernel weight read address generator: sweeps taps, repeats each group
// PASSES times, and delays valid/tap markers to line up with memory data.
module conv_k_mem_addr_gen
    import conv_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TAPS        = CONV2_TAPS,
    parameter int PASSES      = CONV2_PASSES,
    parameter int GROUPS      = CONV2_GROUPS,
    parameter int NUM_PORTS   = 2,
    parameter int PORT_STRIDE = CONV2_PORT_STRIDE,
    parameter int BASE_ADDR   = 0,
    parameter int RD_LAT      = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          enable,
    output logic [NUM_PORTS*ADDR_W-1:0]   addr,
    output logic                          addr_valid,
    output logic [$clog2(TAPS)-1:0]       tap_idx,
    output logic [$clog2(GROUPS)-1:0]     group_idx,
    output logic                          data_valid,
    output logic                          first_tap,
    output logic                          last_tap,
    output logic                          busy,
    output logic                          done
);

    localparam int TW = $clog2(TAPS);
    localparam int GW = $clog2(GROUPS);
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(TAPS);

    if (!addr_range_ok(BASE_ADDR, TAPS, GROUPS, NUM_PORTS,
                       PORT_STRIDE, ADDR_W)) begin : g_range_err
        $error("weight address range exceeds ADDR_W");
    end

    if (RD_LAT < 0 || RD_LAT > 15) begin : g_lat_err
        $error("RD_LAT must be within 0..15");
    end

    state_t          state_q;
    logic [TW-1:0]   tap_q;
    logic [PW-1:0]   pass_q;
    logic [GW-1:0]   grp_q;
    logic [3:0]      dcnt_q;

    logic            run;
    logic            tap_last;
    logic            pass_last;
    logic            grp_last;
    logic            drain_end;

    assign run       = (state_q == RUN);
    assign tap_last  = (tap_q == TW'(TAPS - 1));
    assign pass_last = (pass_q == PW'(PASSES - 1));
    assign grp_last  = (grp_q == GW'(GROUPS - 1));
    assign drain_end = (dcnt_q == 4'(RD_LAT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tap_q   <= '0;
            pass_q  <= '0;
            grp_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        tap_q   <= '0;
                        pass_q  <= '0;
                        grp_q   <= '0;
                        dcnt_q  <= '0;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (tap_last) begin
                            tap_q <= '0;
                            if (pass_last) begin
                                pass_q <= '0;
                                if (grp_last) begin
                                    grp_q   <= '0;
                                    dcnt_q  <= '0;
                                    state_q <= (RD_LAT == 0) ? DONE : DRAIN;
                                end else begin
                                    grp_q <= grp_q + 1'b1;
                                end
                            end else begin
                                pass_q <= pass_q + 1'b1;
                            end
                        end else begin
                            tap_q <= tap_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_end) begin
                        state_q <= DONE;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr_valid = run & enable;
    assign tap_idx    = tap_q;
    assign group_idx  = grp_q;
    assign busy       = run | (state_q == DRAIN);
    assign done       = (state_q == DONE);

    // Addresses are only driven while a run is active; zero otherwise.
    logic [ADDR_W-1:0] tap_base;
    assign tap_base = BASE_A + TAPS_A * ADDR_W'(grp_q) + ADDR_W'(tap_q);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [ADDR_W-1:0] OFS = ADDR_W'(p * PORT_STRIDE);
        assign addr[p*ADDR_W +: ADDR_W] = run ? (tap_base + OFS) : '0;
    end

    logic [2:0] mk_d;
    logic [2:0] mk_q;

    assign mk_d = {addr_valid,
                   addr_valid & (tap_q == '0),
                   addr_valid & tap_last};

    lat_pipe #(
        .W     (3),
        .DEPTH (RD_LAT)
    ) u_lat (
        .clk   (clk),
        .reset (reset),
        .d     (mk_d),
        .q     (mk_q)
    );

    assign data_valid = mk_q[2];
    assign first_tap  = mk_q[2] & mk_q[1];
    assign last_tap   = mk_q[2] & mk_q[0];

endmodule

// File: tb/tb_conv_k_mem_addr_gen.sv
// Directed scoreboard bench: conv2 defaults, a small 2-cycle-latency config
// and a zero-latency config of the same geometry.
module tb_conv_k_mem_addr_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic start_d = 1'b0;
    logic start_s = 1'b0;
    logic start_z = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] addr_d, addr_s, addr_z;
    logic [4:0]  tap_d;
    logic [1:0]  tap_s, tap_z;
    logic [1:0]  grp_d;
    logic [0:0]  grp_s, grp_z;
    logic av_d, dv_d, ft_d, lt_d, busy_d, done_d;
    logic av_s, dv_s, ft_s, lt_s, busy_s, done_s;
    logic av_z, dv_z, ft_z, lt_z, busy_z, done_z;

    conv_k_mem_addr_gen u_d (
        .clk(clk), .reset(reset), .start(start_d), .enable(enable),
        .addr(addr_d), .addr_valid(av_d), .tap_idx(tap_d),
        .group_idx(grp_d), .data_valid(dv_d), .first_tap(ft_d),
        .last_tap(lt_d), .busy(busy_d), .done(done_d)
    );

    conv_k_mem_addr_gen #(
        .TAPS(4), .PASSES(2), .GROUPS(2), .PORT_STRIDE(8), .RD_LAT(2)
    ) u_s (
        .clk(clk), .reset(reset), .start(start_s), .enable(enable),
        .addr(addr_s), .addr_valid(av_s), .tap_idx(tap_s),
        .group_idx(grp_s), .data_valid(dv_s), .first_tap(ft_s),
        .last_tap(lt_s), .busy(busy_s), .done(done_s)
    );

    conv_k_mem_addr_gen #(
        .TAPS(4), .PASSES(2), .GROUPS(2), .PORT_STRIDE(8), .RD_LAT(0)
    ) u_z (
        .clk(clk), .reset(reset), .start(start_z), .enable(enable),
        .addr(addr_z), .addr_valid(av_z), .tap_idx(tap_z),
        .group_idx(grp_z), .data_valid(dv_z), .first_tap(ft_z),
        .last_tap(lt_z), .busy(busy_z), .done(done_z)
    );

    int cur = 0;
    logic [15:0] o_addr;
    logic [1:0]  o_tap;
    logic [0:0]  o_grp;
    logic o_av, o_dv, o_ft, o_lt, o_busy, o_done;

    assign o_addr = (cur == 1) ? addr_z : addr_s;
    assign o_tap  = (cur == 1) ? tap_z  : tap_s;
    assign o_grp  = (cur == 1) ? grp_z  : grp_s;
    assign o_av   = (cur == 1) ? av_z   : av_s;
    assign o_dv   = (cur == 1) ? dv_z   : dv_s;
    assign o_ft   = (cur == 1) ? ft_z   : ft_s;
    assign o_lt   = (cur == 1) ? lt_z   : lt_s;
    assign o_busy = (cur == 1) ? busy_z : busy_s;
    assign o_done = (cur == 1) ? done_z : done_s;

    int total = 0;
    int bad = 0;

    typedef struct {
        int due;
        bit f;
        bit l;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start_z = v;
        else start_s = v;
    endtask

    // Small geometry: T=4, P=2, G=2, stride 8, N=16 reads.
    task automatic run_s(input int sel, input int lat, input bit stall,
                         input bit pulses, input int rst_at,
                         input bit from_done);
        int rd;
        int lastc;
        int cnt_av;
        int cnt_dv;
        bit in_run;
        bit exp_av;
        bit exp_dv;
        int a0;
        exp_t e;
        rd = 0;
        lastc = -1;
        cnt_av = 0;
        cnt_dv = 0;
        sbq.delete();
        cur = sel;
        @(negedge clk);
        if (from_done) begin
            chk("pre_done", 32'(o_done), 1);
            chk("pre_busy", 32'(o_busy), 0);
        end
        set_start(sel, 1'b1);
        enable = 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(posedge clk);
            #1;
            set_start(sel, pulses && (c == 3 || c == 9));
            enable = stall ? (c % 2 == 1) : 1'b1;
            if (c == rst_at) reset = 1'b1;
            @(negedge clk);
            if (c == rst_at) begin
                chk("rst_addr", 32'(o_addr), 0);
                chk("rst_av", 32'(o_av), 0);
                chk("rst_tap", 32'(o_tap), 0);
                chk("rst_grp", 32'(o_grp), 0);
                chk("rst_dv", 32'(o_dv), 0);
                chk("rst_ft", 32'(o_ft), 0);
                chk("rst_lt", 32'(o_lt), 0);
                chk("rst_busy", 32'(o_busy), 0);
                chk("rst_done", 32'(o_done), 0);
                set_start(sel, 1'b0);
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk);
                    #1;
                    if (k == 1) reset = 1'b0;
                    @(negedge clk);
                    chk("post_rst_dv", 32'(o_dv), 0);
                    chk("post_rst_av", 32'(o_av), 0);
                    chk("post_rst_busy", 32'(o_busy), 0);
                    chk("post_rst_done", 32'(o_done), 0);
                end
                sbq.delete();
                return;
            end
            in_run = (rd < 16);
            exp_av = in_run && enable;
            if (in_run) begin
                a0 = (rd / 8) * 4 + rd % 4;
                chk("addr0", 32'(o_addr[7:0]), 32'(a0));
                chk("addr1", 32'(o_addr[15:8]), 32'(a0 + 8));
                chk("tap", 32'(o_tap), 32'(rd % 4));
                chk("group", 32'(o_grp), 32'(rd / 8));
            end
            chk("addr_valid", 32'(o_av), 32'(exp_av));
            if (exp_av) begin
                e.due = c + lat;
                e.f = (rd % 4 == 0);
                e.l = (rd % 4 == 3);
                sbq.push_back(e);
                rd++;
                if (rd == 16) lastc = c;
            end
            exp_dv = (sbq.size() > 0) && (sbq[0].due == c);
            chk("data_valid", 32'(o_dv), 32'(exp_dv));
            if (exp_dv) begin
                e = sbq.pop_front();
                chk("first_tap", 32'(o_ft), 32'(e.f));
                chk("last_tap", 32'(o_lt), 32'(e.l));
            end else begin
                chk("first_tap_idle", 32'(o_ft), 0);
                chk("last_tap_idle", 32'(o_lt), 0);
            end
            chk("busy", 32'(o_busy),
                32'((rd < 16) || (lastc >= 0 && c <= lastc + lat)));
            chk("done", 32'(o_done),
                32'((lastc >= 0) && (c > lastc + lat)));
            if (o_av) cnt_av++;
            if (o_dv) cnt_dv++;
            if (lastc >= 0 && c == lastc + lat + 3) break;
        end
        chk("reads_av", 32'(cnt_av), 16);
        chk("reads_dv", 32'(cnt_dv), 16);
        chk("sb_empty", 32'(sbq.size()), 0);
    endtask

    // conv2 defaults: 4800 reads, RD_LAT=1, done at cycle 4802.
    task automatic run_d();
        int i;
        int a0;
        int cnt;
        cnt = 0;
        @(negedge clk);
        start_d = 1'b1;
        enable = 1'b1;
        for (int c = 1; c <= 4805; c++) begin
            @(posedge clk);
            #1;
            start_d = 1'b0;
            @(negedge clk);
            chk("d_av", 32'(av_d), 32'(c <= 4800));
            if (c <= 4800) begin
                i = c - 1;
                a0 = (i / 1600) * 25 + i % 25;
                chk("d_addr0", 32'(addr_d[7:0]), 32'(a0));
                chk("d_addr1", 32'(addr_d[15:8]), 32'(a0 + 75));
                chk("d_tap", 32'(tap_d), 32'(i % 25));
                chk("d_group", 32'(grp_d), 32'(i / 1600));
            end
            chk("d_dv", 32'(dv_d), 32'(c >= 2 && c <= 4801));
            chk("d_ft", 32'(ft_d), 32'(c >= 2 && c <= 4801 && (c - 2) % 25 == 0));
            chk("d_lt", 32'(lt_d), 32'(c >= 2 && c <= 4801 && (c - 2) % 25 == 24));
            chk("d_done", 32'(done_d), 32'(c >= 4802));
            chk("d_busy", 32'(busy_d), 32'(c <= 4801));
            if (av_d) cnt++;
        end
        chk("d_reads", 32'(cnt), 4800);
    endtask

    initial begin
        #2;
        chk("init_av", 32'(av_s), 0);
        chk("init_dv", 32'(dv_s), 0);
        chk("init_addr", 32'(addr_s), 0);
        chk("init_tap", 32'(tap_s), 0);
        chk("init_busy", 32'(busy_s), 0);
        chk("init_done", 32'(done_s), 0);
        chk("init_addr_d", 32'(addr_d), 0);
        chk("init_done_d", 32'(done_d), 0);
        chk("init_dv_z", 32'(dv_z), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_d();
        run_s(0, 2, 1'b0, 1'b0, 0, 1'b0);
        run_s(0, 2, 1'b1, 1'b0, 0, 1'b1);
        run_s(0, 2, 1'b0, 1'b1, 0, 1'b1);
        run_s(0, 2, 1'b0, 1'b0, 7, 1'b1);
        run_s(0, 2, 1'b0, 1'b0, 0, 1'b0);
        run_s(1, 0, 1'b0, 1'b0, 0, 1'b0);
        run_s(1, 0, 1'b1, 1'b1, 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_k_mem_addr_gen.md
Name: conv_k_mem_addr_gen

Overview:
- Parametrised weight-memory read address generator for convolution layers.
- Drives NUM_PORTS simultaneous kernel read addresses into a weight ROM/RAM.
- Sweeps every tap of a kernel, repeats each kernel group PASSES times (once per output pixel / input channel pass), then advances to the next group.
- Adds start/done handshake, stall, and a latency-matched data_valid/marker pipeline for the MAC datapath; defaults reproduce the conv2 layer (25 taps, 64 passes, 3 groups, 2 ports, port stride 75).

Parameters:
- ADDR_W, 8, weight memory address width
- TAPS, 25, weights per kernel (K*K)
- PASSES, 64, repeats of each group before advancing
- GROUPS, 3, kernel groups swept per run
- NUM_PORTS, 2, parallel read ports
- PORT_STRIDE, 75, address offset between adjacent ports
- BASE_ADDR, 0, address of tap 0, group 0, port 0
- RD_LAT, 1, memory read latency in cycles (0..15)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle run request
- enable  in  1  advance permission; low = stall
- addr  out  NUM_PORTS*ADDR_W  flattened addresses, port p at [p*ADDR_W +: ADDR_W]
- addr_valid  out  1  addr is a live read this cycle
- tap_idx  out  $clog2(TAPS)  current tap
- group_idx  out  $clog2(GROUPS)  current group
- data_valid  out  1  addr_valid delayed RD_LAT cycles (memory data present)
- first_tap  out  1  tap==0 marker, delayed RD_LAT, qualified by data_valid
- last_tap  out  1  tap==TAPS-1 marker, delayed RD_LAT, qualified by data_valid
- busy  out  1  state is RUN or DRAIN
- done  out  1  run complete; level, held in DONE

Behaviour:
- Reset (async): state IDLE; all counters 0; every output 0; delay pipe cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN on the next edge; counters 0.
- RUN: addr_valid = enable. Each enable=1 cycle: tap++; at TAPS-1 tap->0, pass++; at PASSES-1 pass->0, group++; at the last tap/pass/group -> DRAIN (or -> DONE if RD_LAT=0).
- enable=0 in RUN: counters hold, addr holds, addr_valid=0. A bubble enters the delay pipe.
- addr[p] = BASE_ADDR + group*TAPS + tap + p*PORT_STRIDE, computed mod 2^ADDR_W. Combinational from registered counters, zero added latency.
- Elaboration assertion fails if BASE_ADDR + GROUPS*TAPS - 1 + (NUM_PORTS-1)*PORT_STRIDE >= 2^ADDR_W.
- Delay pipe: {addr_valid, tap==0, tap==TAPS-1} shifts every cycle, regardless of enable. RD_LAT=0 makes it a wire.
- DRAIN: counts RD_LAT cycles, then -> DONE. The final data_valid occurs in the last DRAIN cycle.
- DONE: done=1, busy=0.
  - start=1 -> RUN the next cycle (done drops that cycle, counters 0, immediate restart).
  - Otherwise DONE holds indefinitely.
- start during RUN/DRAIN is ignored; no restart, no error.
- Timing, enable held high, start sampled at edge 0:
  - addr_valid cycles 1..N, where N = TAPS*PASSES*GROUPS.
  - data_valid cycles 1+RD_LAT..N+RD_LAT.
  - done from cycle N+RD_LAT+1.
- Reset mid-run: immediate return to IDLE; pending pipe entries discarded; no data_valid after reset deasserts.

Decomposition:
- Package conv_mem_pkg holds:
  - state typedef enum {IDLE, RUN, DRAIN, DONE}
  - default constants CONV2_TAPS=25, CONV2_PASSES=64, CONV2_GROUPS=3, CONV2_PORT_STRIDE=75
  - localparam helper function for the address-range check
- Sub-module lat_pipe #(W, DEPTH): async-reset shift register used for the data_valid/marker delay line; DEPTH=0 passthrough.

Test Plan:
- Defaults, start pulse, enable=1 -> 4800 addr_valid cycles; first addr0=0/addr1=75; addr0 wraps 24->0 at cycle 26; addr0 goes 25 at cycle 1601; last addr0=74, addr1=149; done rises at cycle 4802.
- TAPS=4, PASSES=2, GROUPS=2, PORT_STRIDE=8, RD_LAT=2 -> addr0 sequence 0,1,2,3,0,1,2,3,4,5,6,7,4,5,6,7; addr1 = addr0+8; data_valid cycles 3..18; last_tap on cycles 6,10,14,18; done at cycle 19.
- Small config, enable toggled 1,0,1,0 -> counters advance only on enable=1; data_valid pattern equals addr_valid shifted by exactly 2; total 16 valid reads; done later by the stall count.
- Reset asserted at cycle 7 of a run -> all outputs 0 within the same cycle (async); no data_valid afterwards; a fresh start produces a full 16-read run from addr 0.
- start pulses at cycles 3 and 9 during RUN -> ignored, sequence unchanged. start in DONE -> done=0 and addr_valid=1 with addr0=BASE_ADDR the next cycle.
- RD_LAT=0 -> data_valid equals addr_valid in the same cycle; DRAIN skipped; done at cycle N+1.
